binary_round_ctrl: RTL



---
 rtl/binary_round_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/binary_round_ctrl.sv
// ============================================================================
//  Module      : binary_round_ctrl
//  Description : Round sequencer for one Play session of the binary game:
//                target load, per-round countdown, guess judging, scoring.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module binary_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int TIME_LIMIT = 30
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Select,
    input  logic       Quit,
    input  logic       tick,
    input  logic [7:0] rand_in,
    input  logic [7:0] userNumber,
    output logic [7:0] target,
    output logic [7:0] score,
    output logic [3:0] round,
    output logic [5:0] time_left,
    output logic       correct,
    output logic       q_Idle,
    output logic       q_Load,
    output logic       q_Guess,
    output logic       q_Judge,
    output logic       q_Done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GUESS = 3'd2,
        S_JUDGE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [3:0] c_lastRound = 4'(NUM_ROUNDS);
    localparam logic [5:0] c_timeLimit = 6'(TIME_LIMIT);

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_target;
    logic [7:0] r_score;
    logic [3:0] r_round;
    logic [5:0] r_timeLeft;
    logic       r_hit;
    logic       r_correct;

    logic [3:0] w_roundInc;
    logic       w_expire;

    assign w_roundInc = r_round + 4'd1;
    assign w_expire   = tick && (r_timeLeft == 6'd1);

    // State register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; priority Quit > Select > tick
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) w_nextState = S_LOAD;
            end
            S_LOAD: begin
                w_nextState = Quit ? S_DONE : S_GUESS;
            end
            S_GUESS: begin
                if (Quit)                  w_nextState = S_DONE;
                else if (Select || w_expire) w_nextState = S_JUDGE;
            end
            S_JUDGE: begin
                if (Quit || (w_roundInc == c_lastRound)) w_nextState = S_DONE;
                else                                     w_nextState = S_LOAD;
            end
            S_DONE: begin
                if (Start || Quit) w_nextState = S_IDLE;
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Session datapath
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_target   <= 8'd0;
            r_score    <= 8'd0;
            r_round    <= 4'd0;
            r_timeLeft <= 6'd0;
            r_hit      <= 1'b0;
            r_correct  <= 1'b0;
        end else begin
            r_correct <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_score <= 8'd0;
                        r_round <= 4'd0;
                    end
                end
                S_LOAD: begin
                    // A zero target is not a useful puzzle; substitute 1
                    r_target   <= (rand_in == 8'd0) ? 8'd1 : rand_in;
                    r_timeLeft <= c_timeLimit;
                end
                S_GUESS: begin
                    if (!Quit) begin
                        if (tick && (r_timeLeft != 6'd0)) begin
                            r_timeLeft <= r_timeLeft - 6'd1;
                        end
                        r_hit <= Select && (userNumber == r_target);
                    end
                end
                S_JUDGE: begin
                    if (!Quit) begin
                        r_round <= w_roundInc;
                        if (r_hit) begin
                            r_correct <= 1'b1;
                            if (r_score != 8'hFF) r_score <= r_score + 8'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign target    = r_target;
    assign score     = r_score;
    assign round     = r_round;
    assign time_left = r_timeLeft;
    assign correct   = r_correct;

    assign q_Idle  = (r_state == S_IDLE);
    assign q_Load  = (r_state == S_LOAD);
    assign q_Guess = (r_state == S_GUESS);
    assign q_Judge = (r_state == S_JUDGE);
    assign q_Done  = (r_state == S_DONE);

endmodule

`default_nettype wire
